// File: rtl/muldiv_sequencer_pkg.sv
// +----------------------------------------------------------------------+
// | muldiv_pkg: shared types and constants for the MUL/DIV sequencer     |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

package muldiv_pkg;

    localparam int XLEN = 32;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WAIT  = 2'd1,
        S_DONE  = 2'd2,
        S_DRAIN = 2'd3
    } state_e;

    // funct3[1:0] encodings; op[1] separates quotient (0) from remainder (1)
    localparam logic [1:0] OP_MUL    = 2'b00;
    localparam logic [1:0] OP_MULH   = 2'b01;
    localparam logic [1:0] OP_MULHSU = 2'b10;
    localparam logic [1:0] OP_MULHU  = 2'b11;
    localparam logic [1:0] OP_DIV    = 2'b00;
    localparam logic [1:0] OP_DIVU   = 2'b01;
    localparam logic [1:0] OP_REM    = 2'b10;
    localparam logic [1:0] OP_REMU   = 2'b11;

    localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

endpackage

`default_nettype wire

// File: rtl/muldiv_sequencer_if.sv
// +----------------------------------------------------------------------+
// | muldiv_sequencer_if: launch/completion bus to the MUL and DIV units  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

interface muldiv_sequencer_if;
    import muldiv_pkg::*;

    logic            mul_start_o;
    logic            div_start_o;
    logic [1:0]      unit_op_o;
    logic [XLEN-1:0] unit_a_o;
    logic [XLEN-1:0] unit_b_o;
    logic            mul_done_i;
    logic            div_done_i;
    logic [XLEN-1:0] mul_result_i;
    logic [XLEN-1:0] div_quot_i;
    logic [XLEN-1:0] div_rem_i;

    modport master (
        output mul_start_o, div_start_o, unit_op_o, unit_a_o, unit_b_o,
        input  mul_done_i, div_done_i, mul_result_i, div_quot_i, div_rem_i
    );

    modport slave (
        input  mul_start_o, div_start_o, unit_op_o, unit_a_o, unit_b_o,
        output mul_done_i, div_done_i, mul_result_i, div_quot_i, div_rem_i
    );

endinterface

`default_nettype wire

// File: rtl/muldiv_sequencer_fastpath.sv
// +----------------------------------------------------------------------+
// | muldiv_fastpath: combinational divide-by-zero / overflow resolution  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

module muldiv_fastpath
    import muldiv_pkg::*;
(
    input  wire logic [1:0]      op_i,
    input  wire logic [XLEN-1:0] a_i,
    input  wire logic [XLEN-1:0] b_i,
    output logic                 hit_o,
    output logic [XLEN-1:0]      result_o
);

    always_comb begin
        hit_o    = 1'b0;
        result_o = '0;
        if (b_i == '0) begin
            hit_o    = 1'b1;
            result_o = op_i[1] ? a_i : '1;
        end else if (!op_i[0] && (a_i == INT_MIN) && (b_i == '1)) begin
            // signed overflow only; DIVU/REMU of the same bits are ordinary
            hit_o    = 1'b1;
            result_o = op_i[1] ? '0 : INT_MIN;
        end
    end

endmodule

`default_nettype wire

// File: rtl/muldiv_sequencer.sv
// +----------------------------------------------------------------------+
// | muldiv_sequencer: launches MUL/DIV units and stalls EX until done.   |
// | Option DIV_FASTPATH_EN resolves divide special cases without a launch|
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

module muldiv_sequencer
    import muldiv_pkg::*;
(
    input  wire logic            clk_i,
    input  wire logic            rst_i,
    input  wire logic            start_i,
    input  wire logic            sel_i,
    input  wire logic [1:0]      op_i,
    input  wire logic [XLEN-1:0] rs1_i,
    input  wire logic [XLEN-1:0] rs2_i,
    input  wire logic            flush_i,
    output logic                 stall_o,
    output logic                 busy_o,
    output logic [XLEN-1:0]      result_o,
    output logic                 result_valid_o,
    muldiv_sequencer_if.master   unit_if
);

    state_e          state_q;
    logic            sel_q;
    logic [1:0]      op_q;
    logic [XLEN-1:0] a_q;
    logic [XLEN-1:0] b_q;
    logic [XLEN-1:0] result_q;
    logic            mul_start_q;
    logic            div_start_q;

    logic            w_done;
    logic [XLEN-1:0] w_unit_result;
    logic            w_accept;

`ifdef DIV_FASTPATH_EN
    logic            w_fp_hit;
    logic [XLEN-1:0] w_fp_result;

    muldiv_fastpath u_fastpath (
        .op_i     (op_i),
        .a_i      (rs1_i),
        .b_i      (rs2_i),
        .hit_o    (w_fp_hit),
        .result_o (w_fp_result)
    );
`endif

    // only the running unit's completion counts
    assign w_done        = sel_q ? unit_if.div_done_i : unit_if.mul_done_i;
    assign w_unit_result = !sel_q    ? unit_if.mul_result_i :
                           !op_q[1]  ? unit_if.div_quot_i   : unit_if.div_rem_i;
    assign w_accept      = (state_q == S_IDLE) && start_i && !flush_i;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= S_IDLE;
            sel_q       <= 1'b0;
            op_q        <= '0;
            a_q         <= '0;
            b_q         <= '0;
            result_q    <= '0;
            mul_start_q <= 1'b0;
            div_start_q <= 1'b0;
        end else begin
            mul_start_q <= 1'b0;
            div_start_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (w_accept) begin
                        sel_q <= sel_i;
                        op_q  <= op_i;
                        a_q   <= rs1_i;
                        b_q   <= rs2_i;
`ifdef DIV_FASTPATH_EN
                        if (sel_i && w_fp_hit) begin
                            result_q <= w_fp_result;
                            state_q  <= S_DONE;
                        end else
`endif
                        begin
                            mul_start_q <= !sel_i;
                            div_start_q <= sel_i;
                            state_q     <= S_WAIT;
                        end
                    end
                end
                S_WAIT: begin
                    if (flush_i) begin
                        state_q <= w_done ? S_IDLE : S_DRAIN;
                    end else if (w_done) begin
                        result_q <= w_unit_result;
                        state_q  <= S_DONE;
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                end
                S_DRAIN: begin
                    if (w_done) begin
                        state_q <= S_IDLE;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign stall_o        = w_accept || (state_q == S_WAIT) ||
                            ((state_q == S_DRAIN) && start_i);
    assign busy_o         = (state_q != S_IDLE);
    assign result_valid_o = (state_q == S_DONE) && !flush_i;
    assign result_o       = result_q;

    assign unit_if.mul_start_o = mul_start_q;
    assign unit_if.div_start_o = div_start_q;
    assign unit_if.unit_op_o   = op_q;
    assign unit_if.unit_a_o    = a_q;
    assign unit_if.unit_b_o    = b_q;

endmodule

`default_nettype wire

// File: tb/tb_muldiv_sequencer.sv
// +----------------------------------------------------------------------+
// | tb_muldiv_sequencer: directed self-checking bench for the sequencer  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

module tb_muldiv_sequencer;
    import muldiv_pkg::*;

    logic            clk = 1'b0;
    logic            rst;
    logic            start;
    logic            sel;
    logic [1:0]      op;
    logic [XLEN-1:0] rs1;
    logic [XLEN-1:0] rs2;
    logic            flush;
    logic            stall;
    logic            busy;
    logic [XLEN-1:0] result;
    logic            rvalid;

    int n_checks = 0;
    int n_errors = 0;
    int div_pulses = 0;

    muldiv_sequencer_if u_if ();

    muldiv_sequencer dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .start_i        (start),
        .sel_i          (sel),
        .op_i           (op),
        .rs1_i          (rs1),
        .rs2_i          (rs2),
        .flush_i        (flush),
        .stall_o        (stall),
        .busy_o         (busy),
        .result_o       (result),
        .result_valid_o (rvalid),
        .unit_if        (u_if.master)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (u_if.div_start_o === 1'b1) div_pulses++;
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs;
        start = 0; sel = 0; op = 0; rs1 = 0; rs2 = 0; flush = 0;
        u_if.mul_done_i = 0; u_if.div_done_i = 0;
        u_if.mul_result_i = 0; u_if.div_quot_i = 0; u_if.div_rem_i = 0;
    endtask

    task automatic test_reset;
        idle_inputs();
        rst = 1;
        tick(); tick();
        rst = 0; #1;
        n_checks++; if (stall !== 1'b0) begin n_errors++; $display("FAIL rst_stall: got %b want 0", stall); end
        n_checks++; if (busy !== 1'b0) begin n_errors++; $display("FAIL rst_busy: got %b want 0", busy); end
        n_checks++; if (rvalid !== 1'b0) begin n_errors++; $display("FAIL rst_valid: got %b want 0", rvalid); end
        n_checks++; if (result !== 32'h0) begin n_errors++; $display("FAIL rst_result: got %h want 0", result); end
        n_checks++; if ({u_if.mul_start_o, u_if.div_start_o} !== 2'b00) begin n_errors++; $display("FAIL rst_starts: got %b want 00", {u_if.mul_start_o, u_if.div_start_o}); end
        n_checks++; if ({u_if.unit_op_o, u_if.unit_a_o, u_if.unit_b_o} !== 66'h0) begin n_errors++; $display("FAIL rst_unit_bus: got %h want 0", {u_if.unit_op_o, u_if.unit_a_o, u_if.unit_b_o}); end
    endtask

    task automatic test_mul;
        tick(); start = 1; sel = 0; op = OP_MUL; rs1 = 7; rs2 = 6; #1;
        n_checks++; if (stall !== 1'b1) begin n_errors++; $display("FAIL mul_c0_stall: got %b want 1", stall); end
        tick(); #1;
        n_checks++; if ({u_if.mul_start_o, u_if.div_start_o, stall} !== 3'b101) begin n_errors++; $display("FAIL mul_c1_launch: got %b want 101", {u_if.mul_start_o, u_if.div_start_o, stall}); end
        n_checks++; if ({u_if.unit_a_o, u_if.unit_b_o} !== {32'd7, 32'd6}) begin n_errors++; $display("FAIL mul_c1_operands: got %h want 7/6", {u_if.unit_a_o, u_if.unit_b_o}); end
        tick(); #1;
        n_checks++; if ({u_if.mul_start_o, stall} !== 2'b01) begin n_errors++; $display("FAIL mul_c2: got %b want 01", {u_if.mul_start_o, stall}); end
        tick(); u_if.mul_done_i = 1; u_if.mul_result_i = 42; #1;
        n_checks++; if ({stall, rvalid} !== 2'b10) begin n_errors++; $display("FAIL mul_c3: got %b want 10", {stall, rvalid}); end
        tick(); u_if.mul_done_i = 0; u_if.mul_result_i = 32'hDEAD; #1;
        n_checks++; if ({result, rvalid, stall} !== {32'd42, 2'b10}) begin n_errors++; $display("FAIL mul_c4_result: got %h want 42/valid/nostall", {result, rvalid, stall}); end
        tick(); start = 0; #1;
        n_checks++; if ({busy, rvalid, result} !== {2'b00, 32'd42}) begin n_errors++; $display("FAIL mul_c5_idle_hold: got %h want idle/42", {busy, rvalid, result}); end
    endtask

    task automatic test_back_to_back;
        div_pulses = 0;
        tick(); start = 1; sel = 1; op = OP_DIVU; rs1 = 100; rs2 = 7;
        tick();
        tick(); u_if.div_done_i = 1; u_if.div_quot_i = 14; u_if.div_rem_i = 2;
        tick(); u_if.div_done_i = 0; op = OP_REMU; #1;
        n_checks++; if ({result, rvalid, stall} !== {32'd14, 2'b10}) begin n_errors++; $display("FAIL b2b_divu_result: got %h want 14/valid", {result, rvalid, stall}); end
        tick(); #1;
        n_checks++; if ({busy, stall} !== 2'b01) begin n_errors++; $display("FAIL b2b_accept_after_done: got %b want 01", {busy, stall}); end
        tick(); start = 0; #1;
        n_checks++; if ({u_if.div_start_o, u_if.unit_op_o} !== {1'b1, OP_REMU}) begin n_errors++; $display("FAIL b2b_second_launch: got %b want 1_11", {u_if.div_start_o, u_if.unit_op_o}); end
        tick(); u_if.div_done_i = 1;
        tick(); u_if.div_done_i = 0; #1;
        n_checks++; if ({result, rvalid} !== {32'd2, 1'b1}) begin n_errors++; $display("FAIL b2b_remu_result: got %h want 2/valid", {result, rvalid}); end
        tick(); #1;
        n_checks++; if (div_pulses !== 2) begin n_errors++; $display("FAIL b2b_div_pulses: got %0d want 2", div_pulses); end
    endtask

    task automatic test_flush_drain;
        tick(); start = 1; sel = 1; op = OP_DIV; rs1 = 1000; rs2 = 10;
        tick();
        tick(); start = 0; flush = 1; #1;
        n_checks++; if (stall !== 1'b1) begin n_errors++; $display("FAIL drain_flush_cycle_stall: got %b want 1", stall); end
        tick(); flush = 0; #1;
        n_checks++; if ({busy, stall, rvalid} !== 3'b100) begin n_errors++; $display("FAIL drain_entered: got %b want 100", {busy, stall, rvalid}); end
        tick(); start = 1; sel = 0; op = OP_MUL; rs1 = 3; rs2 = 5; #1;
        n_checks++; if (stall !== 1'b1) begin n_errors++; $display("FAIL drain_held_start_stall: got %b want 1", stall); end
        tick(); u_if.mul_done_i = 1; u_if.mul_result_i = 32'h55;
        tick(); u_if.mul_done_i = 0; #1;
        n_checks++; if ({busy, rvalid} !== 2'b10) begin n_errors++; $display("FAIL drain_ignores_mul_done: got %b want 10", {busy, rvalid}); end
        for (int i = 7; i < 10; i++) tick();
        tick(); u_if.div_done_i = 1; u_if.div_quot_i = 100; #1;
        n_checks++; if ({stall, rvalid} !== 2'b10) begin n_errors++; $display("FAIL drain_done_cycle: got %b want 10", {stall, rvalid}); end
        tick(); u_if.div_done_i = 0; #1;
        n_checks++; if ({busy, stall, rvalid, result} !== {3'b010, 32'd2}) begin n_errors++; $display("FAIL drain_accept_next: got %h want idle/stall/result 2", {busy, stall, rvalid, result}); end
        tick(); start = 1; #1;
        n_checks++; if ({u_if.mul_start_o, u_if.unit_a_o} !== {1'b1, 32'd3}) begin n_errors++; $display("FAIL drain_mul_launch: got %h want 1/3", {u_if.mul_start_o, u_if.unit_a_o}); end
        tick(); u_if.mul_done_i = 1; u_if.mul_result_i = 15;
        tick(); u_if.mul_done_i = 0; #1;
        n_checks++; if ({result, rvalid} !== {32'd15, 1'b1}) begin n_errors++; $display("FAIL drain_mul_result: got %h want 15/valid", {result, rvalid}); end
        tick(); start = 0;
    endtask

    task automatic test_flush_coincident;
        tick(); start = 1; sel = 0; op = OP_MUL; rs1 = 2; rs2 = 3;
        tick();
        tick(); start = 0; flush = 1; u_if.mul_done_i = 1; u_if.mul_result_i = 6;
        tick(); flush = 0; u_if.mul_done_i = 0; #1;
        n_checks++; if ({busy, rvalid, result} !== {2'b00, 32'd15}) begin n_errors++; $display("FAIL coincident_flush: got %h want idle/novalid/15", {busy, rvalid, result}); end
    endtask

    task automatic test_div_special;
        logic [XLEN-1:0] a_vec [2];
        logic [XLEN-1:0] b_vec [2];
        logic [XLEN-1:0] q_vec [2];
        a_vec[0] = 32'd5;        b_vec[0] = 32'd0;        q_vec[0] = 32'hFFFF_FFFF;
        a_vec[1] = 32'h8000_0000; b_vec[1] = 32'hFFFF_FFFF; q_vec[1] = 32'h8000_0000;
        for (int k = 0; k < 2; k++) begin
            div_pulses = 0;
            tick(); start = 1; sel = 1; op = OP_DIV; rs1 = a_vec[k]; rs2 = b_vec[k]; #1;
            n_checks++; if (stall !== 1'b1) begin n_errors++; $display("FAIL special%0d_c0_stall: got %b want 1", k, stall); end
`ifdef DIV_FASTPATH_EN
            tick(); #1;
            n_checks++; if ({result, rvalid, stall} !== {q_vec[k], 2'b10}) begin n_errors++; $display("FAIL special%0d_fast: got %h want %h/valid", k, {result, rvalid, stall}, q_vec[k]); end
            tick(); start = 0; #1;
            n_checks++; if (div_pulses !== 0) begin n_errors++; $display("FAIL special%0d_no_launch: got %0d want 0", k, div_pulses); end
`else
            tick(); #1;
            n_checks++; if (u_if.div_start_o !== 1'b1) begin n_errors++; $display("FAIL special%0d_launch: got %b want 1", k, u_if.div_start_o); end
            tick(); u_if.div_done_i = 1; u_if.div_quot_i = q_vec[k]; u_if.div_rem_i = 32'h1234;
            tick(); u_if.div_done_i = 0; #1;
            n_checks++; if ({result, rvalid} !== {q_vec[k], 1'b1}) begin n_errors++; $display("FAIL special%0d_passthru: got %h want %h/valid", k, {result, rvalid}, q_vec[k]); end
            tick(); start = 0;
`endif
        end
    endtask

    task automatic test_reset_mid_wait;
        tick(); start = 1; sel = 0; op = OP_MULHU; rs1 = 9; rs2 = 9;
        tick();
        tick(); start = 0; rst = 1;
        tick(); rst = 0; u_if.mul_done_i = 1; u_if.mul_result_i = 77; #1;
        n_checks++; if ({busy, stall, u_if.mul_start_o, result, u_if.unit_a_o} !== 67'h0) begin n_errors++; $display("FAIL rst_mid_idle: got %h want 0", {busy, stall, u_if.mul_start_o, result, u_if.unit_a_o}); end
        tick(); u_if.mul_done_i = 0; #1;
        n_checks++; if ({busy, rvalid, result} !== 34'h0) begin n_errors++; $display("FAIL rst_mid_late_done: got %h want 0", {busy, rvalid, result}); end
    endtask

    initial begin
        test_reset();
        test_mul();
        test_back_to_back();
        test_flush_drain();
        test_flush_coincident();
        test_div_special();
        test_reset_mid_wait();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
